psum_scratch_arbiter: RTL and testbench
=======================================

Name: psum_scratch_arbiter

Overview:
- Shares one partial-sum scratchpad between NUM_REQ PE lanes.
- Each granted lane performs either an accumulate (read-modify-write) or an overwrite.
- Pipelined at one access per cycle, with one-deep write forwarding to resolve read-after-write hazards.
- Sits between the PE lanes and the scratchpad. The top-level design controller drives en / flush / clear (clear comes from its clear_regs) and watches flush_done.

Parameters:
- NUM_REQ, 4, number of requesting PE lanes
- SCRATCH_DEPTH, 16, psum scratchpad entries
- SCRATCH_WIDTH, 16, psum width in bits (two's complement)
- ADDR_LEN, 4, scratchpad address width; must equal clog2(SCRATCH_DEPTH)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  allows arbitration; sampled in IDLE
- clear  input  1  synchronous soft clear, from controller clear_regs
- flush  input  1  stop granting and drain the pipeline
- req  input  NUM_REQ  per-lane request, held until granted
- req_acc  input  NUM_REQ  per lane: 1 = accumulate, 0 = overwrite
- req_addr  input  NUM_REQ*ADDR_LEN  per-lane address; lane i occupies bits [i*ADDR_LEN +: ADDR_LEN]
- req_data  input  NUM_REQ*SCRATCH_WIDTH  per-lane operand, packed the same way
- gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as the request
- mem_ren  output  1  scratchpad read enable
- mem_raddr  output  ADDR_LEN  scratchpad read address
- mem_rdata  input  SCRATCH_WIDTH  read data, valid the cycle after mem_ren; read-old-data on a same-cycle write
- mem_wen  output  1  scratchpad write enable
- mem_waddr  output  ADDR_LEN  write address
- mem_wdata  output  SCRATCH_WIDTH  write data
- busy  output  1  high when the state is not IDLE or stage 1 is valid
- ovf  output  1  sticky accumulate overflow flag
- flush_done  output  1  one-cycle pulse when the drain completes

Behaviour:
- Reset (rst=0, asynchronous) and clear (synchronous) have the same effect:
  - state goes to IDLE, RR pointer to 0, stage-1 valid to 0, forward-valid to 0, ovf to 0.
  - All outputs are 0, including gnt, mem_*, busy and flush_done.
  - An in-flight stage-1 write is dropped; it is not written.
- States:
  - IDLE -> ARB when en=1.
  - ARB -> DRAIN when flush=1. Flush has priority: no grant is issued in the flush cycle.
  - DRAIN -> DONE when stage 1 is invalid.
  - DONE -> IDLE unconditionally; flush_done=1 only in DONE.
- Arbitration (ARB only):
  - Search req round-robin starting at the RR pointer and grant the first lane found; gnt is one-hot.
  - On a grant to lane k, the pointer becomes (k+1) mod NUM_REQ.
  - No req means no grant and the pointer holds.
  - A lane holds req/addr/data until gnt is seen; it may present a new request the following cycle.
- Stage 0 (grant cycle t):
  - mem_ren = gnt & req_acc[k]; mem_raddr = addr[k].
  - Latch addr, data and acc into stage 1; stage-1 valid is set at the t+1 edge.
- Stage 1 (cycle t+1):
  - Operand = fwd_addr==s1_addr && fwd_valid ? fwd_data : mem_rdata.
  - mem_wdata = acc ? operand+data : data; mem_wen=1; mem_waddr = s1_addr.
  - Register (waddr, wdata) into fwd, with fwd_valid=1, at the t+2 edge.
- Forwarding covers back-to-back hits on the same address. The memory write is visible to reads issued two or more cycles later.
- Throughput is 1 per cycle; latency from grant to write is 1 cycle.
- Arithmetic is SCRATCH_WIDTH-bit signed and wraps (truncates). ovf is set when both operand signs are equal and the result sign differs; it stays set until rst or clear.
- fwd_valid is cleared by rst/clear and on entering IDLE.

Decomposition:
- The shared package holds:
  - state encodings IDLE=0, ARB=1, DRAIN=2, DONE=3
  - localparam ST_W=2
  - the lane-slice width helpers
- One sub-module, rr_arbiter:
  - parameter N
  - inputs req and en, outputs one-hot gnt
  - internal pointer with async active-low reset and synchronous clear

Test Plan:
- Single overwrite: lane 0 writes addr 3, data 0x0005 -> gnt[0] at t, mem_wen at t+1 with mem_waddr=3, mem_wdata=0x0005.
- Round-robin: all 4 lanes request continuously -> grant order 0,1,2,3,0, one per cycle, no gaps, pointer wraps.
- RAW forward: mem[2]=10; lane 1 accumulates +3 to addr 2, then lane 2 accumulates +4 to addr 2 the next cycle -> writes 13, then 17, not 14.
- Overflow: mem[5]=0x7FFF, accumulate +1 -> mem_wdata=0x8000 and ovf=1, held until clear.
- Flush with req held: flush in the same cycle as a pending req -> no gnt; the in-flight write completes; flush_done pulses 2 cycles after flush; state returns to IDLE.
- Reset/clear mid-op: rst=0 while stage 1 is valid -> no mem_wen and all outputs 0 immediately; clear does the same at the next edge and the pointer returns to 0.

Source files
------------

// File: rtl/psum_scratch_arbiter_pkg.sv
// Shared definitions for the partial-sum scratchpad arbiter: FSM encodings
// and helpers for slicing the packed per-lane request buses.
package psum_scratch_arbiter_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_ARB   = 2'd1;
  localparam logic [ST_W-1:0] ST_DRAIN = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

  // Width of an index able to address n items (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lowest bit of lane 'lane' in a bus packed as lanes of 'width' bits.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/psum_scratch_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer that
// moves just past the most recently granted requester.
module rr_arbiter
  import psum_scratch_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = idx_w(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] cand;
  logic [PW-1:0] gnt_idx;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = PW'((int'(ptr) + i) % N);
      if (en && req[cand]) begin
        gnt          = '0;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

  // Pointer advances past the granted lane and holds when nothing is granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= PW'((int'(gnt_idx) + 1) % N);
    end
  end

endmodule

// File: rtl/psum_scratch_arbiter.sv
// Shares one partial-sum scratchpad between NUM_REQ PE lanes. Each grant is a
// two-stage read-modify-write (or plain overwrite) at one access per cycle;
// the last write is held in a forwarding register so back-to-back accesses
// to the same address see the fresh value instead of the stale memory read.
module psum_scratch_arbiter
  import psum_scratch_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SCRATCH_DEPTH = 16,
  parameter int SCRATCH_WIDTH = 16,
  parameter int ADDR_LEN      = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                clear,
  input  logic                                flush,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0]                  req_acc,
  input  logic [NUM_REQ*ADDR_LEN-1:0]         req_addr,
  input  logic [NUM_REQ*SCRATCH_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]                  gnt,
  output logic                                mem_ren,
  output logic [ADDR_LEN-1:0]                 mem_raddr,
  input  logic [SCRATCH_WIDTH-1:0]            mem_rdata,
  output logic                                mem_wen,
  output logic [ADDR_LEN-1:0]                 mem_waddr,
  output logic [SCRATCH_WIDTH-1:0]            mem_wdata,
  output logic                                busy,
  output logic                                ovf,
  output logic                                flush_done
);

  localparam int KW = idx_w(NUM_REQ);

  if (ADDR_LEN != $clog2(SCRATCH_DEPTH)) begin : g_addr_len_check
    $error("ADDR_LEN must equal clog2(SCRATCH_DEPTH)");
  end

  // Two's-complement add that wraps to SCRATCH_WIDTH bits.
  function automatic logic signed [SCRATCH_WIDTH-1:0] add_wrap(
    input logic signed [SCRATCH_WIDTH-1:0] a,
    input logic signed [SCRATCH_WIDTH-1:0] b
  );
    return a + b;
  endfunction

  // Signed overflow: like-signed operands producing an opposite-signed sum.
  function automatic logic add_ovf(
    input logic signed [SCRATCH_WIDTH-1:0] a,
    input logic signed [SCRATCH_WIDTH-1:0] b,
    input logic signed [SCRATCH_WIDTH-1:0] s
  );
    return (a[SCRATCH_WIDTH-1] == b[SCRATCH_WIDTH-1]) &&
           (s[SCRATCH_WIDTH-1] != a[SCRATCH_WIDTH-1]);
  endfunction

  logic [ST_W-1:0]                  st;
  logic [ST_W-1:0]                  st_nxt;
  logic                             arb_en;

  logic                             gnt_any_p0;
  logic [KW-1:0]                    k_p0;
  logic [ADDR_LEN-1:0]              addr_p0;
  logic signed [SCRATCH_WIDTH-1:0]  data_p0;
  logic                             acc_p0;

  logic                             vld_p1;
  logic [ADDR_LEN-1:0]              addr_p1;
  logic signed [SCRATCH_WIDTH-1:0]  data_p1;
  logic                             acc_p1;
  logic signed [SCRATCH_WIDTH-1:0]  operand_p1;
  logic signed [SCRATCH_WIDTH-1:0]  sum_p1;
  logic signed [SCRATCH_WIDTH-1:0]  wdata_p1;
  logic                             ovf_p1;
  logic                             wen_p1;

  logic                             fwd_vld_p2;
  logic [ADDR_LEN-1:0]              fwd_addr_p2;
  logic signed [SCRATCH_WIDTH-1:0]  fwd_data_p2;

  // Flush and clear both win over arbitration in the cycle they are raised.
  assign arb_en = (st == ST_ARB) && !flush && !clear;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (arb_en),
    .req   (req),
    .gnt   (gnt)
  );

  // ---- stage 0: grant cycle, select the winning lane and issue the read ----
  // Convert the one-hot grant into a lane index.
  always_comb begin
    k_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) k_p0 = KW'(i);
    end
  end

  assign gnt_any_p0 = |gnt;
  assign addr_p0    = req_addr[lane_lsb(int'(k_p0), ADDR_LEN) +: ADDR_LEN];
  assign data_p0    = $signed(req_data[lane_lsb(int'(k_p0), SCRATCH_WIDTH) +: SCRATCH_WIDTH]);
  assign acc_p0     = req_acc[k_p0];

  assign mem_ren    = gnt_any_p0 & acc_p0;
  assign mem_raddr  = gnt_any_p0 ? addr_p0 : '0;

  // ---- stage 1: operand select (forward or memory), add, write back ----
  assign operand_p1 = (fwd_vld_p2 && (fwd_addr_p2 == addr_p1)) ? fwd_data_p2
                                                                : $signed(mem_rdata);
  assign sum_p1     = add_wrap(operand_p1, data_p1);
  assign ovf_p1     = add_ovf(operand_p1, data_p1, sum_p1);
  assign wdata_p1   = acc_p1 ? sum_p1 : data_p1;

  // A clear arriving while a write is in flight drops that write.
  assign wen_p1     = vld_p1 & ~clear;
  assign mem_wen    = wen_p1;
  assign mem_waddr  = wen_p1 ? addr_p1 : '0;
  assign mem_wdata  = wen_p1 ? wdata_p1 : '0;

  assign busy       = (st != ST_IDLE) || vld_p1;
  assign flush_done = (st == ST_DONE);

  // Controller sequencing: arbitrate until flushed, then drain and report.
  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:  if (en)      st_nxt = ST_ARB;
      ST_ARB:   if (flush)   st_nxt = ST_DRAIN;
      ST_DRAIN: if (!vld_p1) st_nxt = ST_DONE;
      default:               st_nxt = ST_IDLE;
    endcase
  end

  // Control state: FSM, stage valids and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= ST_IDLE;
      vld_p1     <= 1'b0;
      fwd_vld_p2 <= 1'b0;
      ovf        <= 1'b0;
    end else if (clear) begin
      st         <= ST_IDLE;
      vld_p1     <= 1'b0;
      fwd_vld_p2 <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      st     <= st_nxt;
      vld_p1 <= gnt_any_p0;
      if (st == ST_DONE) begin
        fwd_vld_p2 <= 1'b0;
      end else if (wen_p1) begin
        fwd_vld_p2 <= 1'b1;
      end
      if (wen_p1 && acc_p1 && ovf_p1) begin
        ovf <= 1'b1;
      end
    end
  end

  // ---- stage 2: forwarding register holds the most recent write ----
  // Datapath registers; their valids above qualify every use.
  always_ff @(posedge clk) begin
    if (gnt_any_p0) begin
      addr_p1 <= addr_p0;
      data_p1 <= data_p0;
      acc_p1  <= acc_p0;
    end
    if (wen_p1) begin
      fwd_addr_p2 <= addr_p1;
      fwd_data_p2 <= wdata_p1;
    end
  end

endmodule

// File: tb/tb_psum_scratch_arbiter.sv
// Bench for psum_scratch_arbiter: a behavioural scratchpad, a grant-order
// reference memory feeding a write scoreboard, a round-robin vector table and
// hand-written sequences for forwarding, overflow, flush, clear and reset.
module tb_psum_scratch_arbiter;

  localparam int NR = 4;
  localparam int AW = 4;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              clear;
  logic              flush;
  logic [NR-1:0]     req;
  logic [NR-1:0]     req_acc;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     gnt;
  logic              mem_ren;
  logic [AW-1:0]     mem_raddr;
  logic [DW-1:0]     mem_rdata;
  logic              mem_wen;
  logic [AW-1:0]     mem_waddr;
  logic [DW-1:0]     mem_wdata;
  logic              busy;
  logic              ovf;
  logic              flush_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  psum_scratch_arbiter #(
    .NUM_REQ       (NR),
    .SCRATCH_DEPTH (16),
    .SCRATCH_WIDTH (DW),
    .ADDR_LEN      (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clear      (clear),
    .flush      (flush),
    .req        (req),
    .req_acc    (req_acc),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .gnt        (gnt),
    .mem_ren    (mem_ren),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .ovf        (ovf),
    .flush_done (flush_done)
  );

  // Scratchpad: registered read, read-old-data on a same-cycle write.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_raddr];
    if (mem_wen) mem[mem_waddr] <= mem_wdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: each grant is applied in order to a reference memory and the
  // resulting write is queued; each DUT write pops and compares.
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } sb_t;
  sb_t           sb [$];
  logic [DW-1:0] ref_mem [16];
  sb_t           sb_e;
  int            sb_k;
  logic [AW-1:0] sb_a;
  logic [DW-1:0] sb_d;
  logic [DW-1:0] sb_v;

  always @(negedge clk) begin
    if (mem_wen) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_write waddr=%0h wdata=%0h expected=no_write", mem_waddr, mem_wdata);
      end else begin
        sb_e = sb.pop_front();
        check("sb_waddr", 64'(mem_waddr), 64'(sb_e.addr));
        check("sb_wdata", 64'(mem_wdata), 64'(sb_e.data));
      end
    end
    if (|gnt) begin
      check("sb_gnt_onehot", 64'($countones(gnt)), 64'd1);
      sb_k = 0;
      for (int i = 0; i < NR; i++) if (gnt[i]) sb_k = i;
      sb_a = req_addr[sb_k*AW +: AW];
      sb_d = req_data[sb_k*DW +: DW];
      sb_v = req_acc[sb_k] ? (ref_mem[sb_a] + sb_d) : sb_d;
      ref_mem[sb_a] = sb_v;
      sb.push_back('{sb_a, sb_v});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic r, input logic a,
                          input logic [AW-1:0] ad, input logic [DW-1:0] d);
    req[i]              = r;
    req_acc[i]          = a;
    req_addr[i*AW +: AW] = ad;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic clear_lanes();
    req      = '0;
    req_acc  = '0;
    req_addr = '0;
    req_data = '0;
  endtask

  task automatic all_lanes_ovw(input logic [DW-1:0] base);
    for (int i = 0; i < NR; i++) set_lane(i, 1'b1, 1'b0, AW'(12 + i), base + DW'(i));
  endtask

  task automatic check_quiet(input string name);
    check(name, {gnt, mem_ren, mem_wen, busy, ovf, flush_done, mem_raddr, mem_waddr, mem_wdata}, 64'd0);
  endtask

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] acc;
    logic [NR-1:0] exp_gnt;
    logic [DW-1:0] base;
  } vec_t;
  vec_t vec [10];

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Lane i uses address 12+i and operand base+i.
    vec[0] = '{4'b1111, 4'b0000, 4'b0001, 16'h0100};
    vec[1] = '{4'b1111, 4'b0000, 4'b0010, 16'h0200};
    vec[2] = '{4'b1111, 4'b0000, 4'b0100, 16'h0300};
    vec[3] = '{4'b1111, 4'b0000, 4'b1000, 16'h0400};
    vec[4] = '{4'b1111, 4'b0000, 4'b0001, 16'h0500};
    vec[5] = '{4'b0000, 4'b0000, 4'b0000, 16'h0600};
    vec[6] = '{4'b1001, 4'b0000, 4'b1000, 16'h0700};
    vec[7] = '{4'b0011, 4'b0000, 4'b0001, 16'h0800};
    vec[8] = '{4'b0110, 4'b0110, 4'b0010, 16'h0010};
    vec[9] = '{4'b0101, 4'b0101, 4'b0100, 16'h0020};

    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    clear_lanes();
    rst = 1'b0; clear = 1'b0; flush = 1'b0; en = 1'b1;
    req = '1;

    // Reset state with requests pending.
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset_outs");
    clear_lanes();
    rst = 1'b1;
    step();

    // Round-robin and mixed-request table.
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < NR; i++)
        set_lane(i, vec[v].req[i], vec[v].acc[i], AW'(12 + i), vec[v].base + DW'(i));
      @(negedge clk);
      check($sformatf("rr_gnt%0d", v), 64'(gnt), 64'(vec[v].exp_gnt));
      step();
    end
    clear_lanes();
    step();

    // Single overwrite.
    set_lane(0, 1'b1, 1'b0, 4'd3, 16'h0005);
    @(negedge clk);
    check("ovw_gnt", 64'(gnt), 64'b0001);
    check("ovw_ren", 64'(mem_ren), 64'd0);
    step();
    clear_lanes();
    @(negedge clk);
    check("ovw_wen", 64'(mem_wen), 64'd1);
    check("ovw_waddr", 64'(mem_waddr), 64'd3);
    check("ovw_wdata", 64'(mem_wdata), 64'h0005);
    check("ovw_busy", 64'(busy), 64'd1);
    step();

    // Read-after-write forwarding on address 2.
    set_lane(0, 1'b1, 1'b0, 4'd2, 16'd10);
    step();
    clear_lanes();
    step();
    step();
    set_lane(1, 1'b1, 1'b1, 4'd2, 16'd3);
    @(negedge clk);
    check("raw_gnt1", 64'(gnt), 64'b0010);
    check("raw_ren", 64'(mem_ren), 64'd1);
    check("raw_raddr", 64'(mem_raddr), 64'd2);
    step();
    clear_lanes();
    set_lane(2, 1'b1, 1'b1, 4'd2, 16'd4);
    @(negedge clk);
    check("raw_gnt2", 64'(gnt), 64'b0100);
    check("raw_wdata1", 64'(mem_wdata), 64'd13);
    step();
    clear_lanes();
    @(negedge clk);
    check("raw_wdata2", 64'(mem_wdata), 64'd17);
    step();

    // Accumulate overflow 0x7FFF + 1.
    set_lane(3, 1'b1, 1'b0, 4'd5, 16'h7FFF);
    step();
    clear_lanes();
    step();
    step();
    set_lane(0, 1'b1, 1'b1, 4'd5, 16'h0001);
    @(negedge clk);
    check("ovf_gnt", 64'(gnt), 64'b0001);
    step();
    clear_lanes();
    @(negedge clk);
    check("ovf_wdata", 64'(mem_wdata), 64'h8000);
    check("ovf_before_edge", 64'(ovf), 64'd0);
    step();
    @(negedge clk);
    check("ovf_set", 64'(ovf), 64'd1);
    repeat (3) step();
    @(negedge clk);
    check("ovf_hold", 64'(ovf), 64'd1);

    // Clear with stage 1 valid; pointer returns to lane 0.
    set_lane(1, 1'b1, 1'b0, 4'd10, 16'hAAAA);
    @(negedge clk);
    check("clr_gnt", 64'(gnt), 64'b0010);
    step();
    clear_lanes();
    clear = 1'b1;
    step();
    clear = 1'b0;
    sb.delete();
    @(negedge clk);
    check_quiet("clr_outs");
    step();
    all_lanes_ovw(16'h0C00);
    @(negedge clk);
    check("clr_ptr", 64'(gnt), 64'b0001);
    step();
    clear_lanes();
    step();

    // Flush with a request pending.
    set_lane(2, 1'b1, 1'b0, 4'd11, 16'h0B0B);
    @(negedge clk);
    check("fl_gnt", 64'(gnt), 64'b0100);
    step();
    clear_lanes();
    set_lane(3, 1'b1, 1'b0, 4'd7, 16'h0707);
    flush = 1'b1;
    en = 1'b0;
    @(negedge clk);
    check("fl_nogrant", 64'(gnt), 64'd0);
    check("fl_wen", 64'(mem_wen), 64'd1);
    check("fl_waddr", 64'(mem_waddr), 64'd11);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("fl_done_drain", 64'(flush_done), 64'd0);
    check("fl_busy", 64'(busy), 64'd1);
    step();
    @(negedge clk);
    check("fl_done_pulse", 64'(flush_done), 64'd1);
    step();
    @(negedge clk);
    check("fl_done_after", 64'(flush_done), 64'd0);
    check("fl_idle_busy", 64'(busy), 64'd0);
    check("fl_idle_gnt", 64'(gnt), 64'd0);
    clear_lanes();

    // Asynchronous reset with stage 1 valid.
    en = 1'b1;
    step();
    set_lane(0, 1'b1, 1'b0, 4'd9, 16'h0909);
    @(negedge clk);
    check("rs_gnt", 64'(gnt), 64'b0001);
    step();
    check("rs_wen_pre", 64'(mem_wen), 64'd1);
    rst = 1'b0;
    #1;
    check_quiet("rs_outs");
    sb.delete();
    step();
    step();
    clear_lanes();
    rst = 1'b1;
    step();
    all_lanes_ovw(16'h0D00);
    @(negedge clk);
    check("rs_ptr", 64'(gnt), 64'b0001);
    step();
    clear_lanes();
    step();
    step();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
